// File: rtl/aqua_lsu_pkg.sv
// aqua_lsu_pkg: shared constants for the aqua RV32I load/store unit.
// Holds the funct3 width/sign codes, the FSM state encoding, the
// word-align mask and a small funct3 legality helper.
// Optional feature macro used by the LSU files: AQUA_LSU_RMW_EN.
package aqua_lsu_pkg;

  localparam int unsigned LSU_XLEN    = 32;
  localparam int unsigned LSU_F3_W    = 3;
  localparam int unsigned LSU_RD_W    = 5;
  localparam int unsigned LSU_STATE_W = 3;

  // Load funct3 codes
  localparam logic [LSU_F3_W-1:0] F3_LB  = 3'b000;
  localparam logic [LSU_F3_W-1:0] F3_LH  = 3'b001;
  localparam logic [LSU_F3_W-1:0] F3_LW  = 3'b010;
  localparam logic [LSU_F3_W-1:0] F3_LBU = 3'b100;
  localparam logic [LSU_F3_W-1:0] F3_LHU = 3'b101;
  // Store funct3 codes
  localparam logic [LSU_F3_W-1:0] F3_SB  = 3'b000;
  localparam logic [LSU_F3_W-1:0] F3_SH  = 3'b001;
  localparam logic [LSU_F3_W-1:0] F3_SW  = 3'b010;

  // FSM state encoding
  localparam logic [LSU_STATE_W-1:0] ST_IDLE   = 3'd0;
  localparam logic [LSU_STATE_W-1:0] ST_LOAD   = 3'd1;
  localparam logic [LSU_STATE_W-1:0] ST_RMW_RD = 3'd2;
  localparam logic [LSU_STATE_W-1:0] ST_WRITE  = 3'd3;
  localparam logic [LSU_STATE_W-1:0] ST_RESP   = 3'd4;

  localparam logic [LSU_XLEN-1:0] WORD_ALIGN_MASK = 32'hFFFF_FFFC;

  // Loads reject 011, 110 and 111
  function automatic logic load_f3_valid(input logic [LSU_F3_W-1:0] f3);
    return !((f3 == 3'b011) || (f3[2:1] == 2'b11));
  endfunction

endpackage

// File: rtl/aqua_lsu_align.sv
// aqua_lsu_align: combinational lane logic for the LSU.
// Ports:
//   i_word        read word from memory
//   i_addr_lo     byte offset addr[1:0]
//   i_funct3      RV32I width/sign code
//   o_load_data   selected and sign/zero-extended load value
//   i_store_data  store data, low lanes used (AQUA_LSU_RMW_EN only)
//   o_merged      read word with the store lane replaced (AQUA_LSU_RMW_EN only)
module aqua_lsu_align
  import aqua_lsu_pkg::*;
(
  input  logic [LSU_XLEN-1:0] i_word,
  input  logic [1:0]          i_addr_lo,
  input  logic [LSU_F3_W-1:0] i_funct3,
`ifdef AQUA_LSU_RMW_EN
  input  logic [LSU_XLEN-1:0] i_store_data,
  output logic [LSU_XLEN-1:0] o_merged,
`endif
  output logic [LSU_XLEN-1:0] o_load_data
);

  logic [4:0]          w_shamt;
  logic [LSU_XLEN-1:0] w_shift;

  assign w_shamt = {i_addr_lo, 3'b000};
  assign w_shift = i_word >> w_shamt;

  // Lane select and extension; legal words always have offset 0
  always_comb begin
    o_load_data = w_shift;
    case (i_funct3)
      F3_LB:   o_load_data = {{24{w_shift[7]}}, w_shift[7:0]};
      F3_LH:   o_load_data = {{16{w_shift[15]}}, w_shift[15:0]};
      F3_LBU:  o_load_data = {24'h0, w_shift[7:0]};
      F3_LHU:  o_load_data = {16'h0, w_shift[15:0]};
      default: o_load_data = w_shift;
    endcase
  end

`ifdef AQUA_LSU_RMW_EN
  logic [LSU_XLEN-1:0] w_lane_mask;
  logic [LSU_XLEN-1:0] w_lane_data;

  // Byte or half lane replaced in the read word
  always_comb begin
    w_lane_mask = (i_funct3 == F3_SB) ? 32'h0000_00FF : 32'h0000_FFFF;
    w_lane_data = (i_store_data & w_lane_mask) << w_shamt;
    w_lane_mask = w_lane_mask << w_shamt;
    o_merged    = (i_word & ~w_lane_mask) | w_lane_data;
  end
`endif

endmodule

// File: rtl/aqua_lsu_rv32i.sv
// aqua_lsu_rv32i: MEM-stage load/store unit between the EX->MEM register
// and the D-side port of the TDM arbiter. Issues word-aligned transactions,
// extends load data, and performs sub-word stores as read-modify-write.
// Optional feature macro: AQUA_LSU_RMW_EN (SB/SH via RMW; otherwise illegal).
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   reqValid/isLoad/isStore     request strobe and kind (sampled in IDLE)
//   funct3/addrIn/storeDataIn   width code, byte address, rs2 value
//   rdIn/rdOut                  destination register in / captured
//   lsuBusy                     unit not idle
//   memDAddr/memDData/wr/reqD   arbiter request side
//   memDReady/memDataOutReg     arbiter completion pulse and read data
//   done/wbValid/loadData       completion, write-back valid, load result
//   misaligned/illegal          error flags, valid with done
module aqua_lsu_rv32i
  import aqua_lsu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  reqValid,
  input  logic                  isLoad,
  input  logic                  isStore,
  input  logic [2:0]            funct3,
  input  logic [ADDR_WIDTH-1:0] addrIn,
  input  logic [DATA_WIDTH-1:0] storeDataIn,
  input  logic [4:0]            rdIn,
  output logic                  lsuBusy,
  output logic [ADDR_WIDTH-1:0] memDAddr,
  output logic [DATA_WIDTH-1:0] memDData,
  output logic                  wr,
  output logic                  reqD,
  input  logic                  memDReady,
  input  logic [DATA_WIDTH-1:0] memDataOutReg,
  output logic                  done,
  output logic                  wbValid,
  output logic [DATA_WIDTH-1:0] loadData,
  output logic [4:0]            rdOut,
  output logic                  misaligned,
  output logic                  illegal
);

  logic [LSU_STATE_W-1:0] r_state, w_state_nxt;
  logic [1:0]             r_addr_lo, w_addr_lo_nxt;
  logic [LSU_F3_W-1:0]    r_funct3, w_funct3_nxt;

  logic                  w_busy_nxt, w_reqd_nxt, w_wr_nxt, w_done_nxt;
  logic                  w_wbvalid_nxt, w_mis_nxt, w_ill_nxt;
  logic [ADDR_WIDTH-1:0] w_daddr_nxt;
  logic [DATA_WIDTH-1:0] w_ddata_nxt, w_load_nxt;
  logic [4:0]            w_rd_nxt;

  logic                  w_accept, w_f3_valid, w_misaligned, w_illegal, w_subword;
  logic [DATA_WIDTH-1:0] w_load_ext;
`ifdef AQUA_LSU_RMW_EN
  logic [DATA_WIDTH-1:0] w_merged;
`endif

  // Request decode; a load+store request is treated as a load
  always_comb begin
    w_accept     = reqValid & (isLoad | isStore);
    w_f3_valid   = isLoad ? load_f3_valid(funct3) : (funct3 < 3'd3);
    w_misaligned = w_f3_valid &
                   (((funct3[1:0] == 2'b01) & addrIn[0]) |
                    ((funct3[1:0] == 2'b10) & (addrIn[1:0] != 2'b00)));
    w_subword    = ~isLoad & (funct3 != F3_SW);
`ifdef AQUA_LSU_RMW_EN
    w_illegal    = ~w_f3_valid;
`else
    w_illegal    = ~w_f3_valid | w_subword;
`endif
  end

  aqua_lsu_align u_align (
    .i_word       (memDataOutReg),
    .i_addr_lo    (r_addr_lo),
    .i_funct3     (r_funct3),
`ifdef AQUA_LSU_RMW_EN
    .i_store_data (memDData),
    .o_merged     (w_merged),
`endif
    .o_load_data  (w_load_ext)
  );

  // Next state and next registered outputs
  always_comb begin
    w_state_nxt   = r_state;
    w_addr_lo_nxt = r_addr_lo;
    w_funct3_nxt  = r_funct3;
    w_reqd_nxt    = reqD;
    w_wr_nxt      = wr;
    w_daddr_nxt   = memDAddr;
    w_ddata_nxt   = memDData;
    w_load_nxt    = loadData;
    w_rd_nxt      = rdOut;
    w_done_nxt    = 1'b0;
    w_wbvalid_nxt = 1'b0;
    w_mis_nxt     = 1'b0;
    w_ill_nxt     = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_addr_lo_nxt = addrIn[1:0];
          w_funct3_nxt  = funct3;
          w_daddr_nxt   = addrIn & ADDR_WIDTH'(WORD_ALIGN_MASK);
          w_ddata_nxt   = storeDataIn;
          if (isLoad) w_rd_nxt = rdIn;
          if (w_misaligned | w_illegal) begin
            w_state_nxt = ST_RESP;
            w_done_nxt  = 1'b1;
            w_mis_nxt   = w_misaligned;
            w_ill_nxt   = w_illegal;
          end else if (isLoad) begin
            w_state_nxt = ST_LOAD;
            w_reqd_nxt  = 1'b1;
            w_wr_nxt    = 1'b0;
`ifdef AQUA_LSU_RMW_EN
          end else if (w_subword) begin
            w_state_nxt = ST_RMW_RD;
            w_reqd_nxt  = 1'b1;
            w_wr_nxt    = 1'b0;
`endif
          end else begin
            w_state_nxt = ST_WRITE;
            w_reqd_nxt  = 1'b1;
            w_wr_nxt    = 1'b1;
          end
        end
      end
      ST_LOAD: begin
        if (memDReady) begin
          w_state_nxt   = ST_RESP;
          w_reqd_nxt    = 1'b0;
          w_load_nxt    = w_load_ext;
          w_done_nxt    = 1'b1;
          w_wbvalid_nxt = 1'b1;
        end
      end
`ifdef AQUA_LSU_RMW_EN
      // Read phase done: request stays up and turns into the write
      ST_RMW_RD: begin
        if (memDReady) begin
          w_state_nxt = ST_WRITE;
          w_ddata_nxt = w_merged;
          w_wr_nxt    = 1'b1;
        end
      end
`endif
      ST_WRITE: begin
        if (memDReady) begin
          w_state_nxt = ST_RESP;
          w_reqd_nxt  = 1'b0;
          w_wr_nxt    = 1'b0;
          w_done_nxt  = 1'b1;
        end
      end
      ST_RESP: w_state_nxt = ST_IDLE;
      default: begin
        w_state_nxt = ST_IDLE;
        w_reqd_nxt  = 1'b0;
        w_wr_nxt    = 1'b0;
      end
    endcase

    w_busy_nxt = (w_state_nxt != ST_IDLE);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_addr_lo  <= 2'b00;
      r_funct3   <= '0;
      lsuBusy    <= 1'b0;
      reqD       <= 1'b0;
      wr         <= 1'b0;
      memDAddr   <= '0;
      memDData   <= '0;
      done       <= 1'b0;
      wbValid    <= 1'b0;
      misaligned <= 1'b0;
      illegal    <= 1'b0;
      loadData   <= '0;
      rdOut      <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_addr_lo  <= w_addr_lo_nxt;
      r_funct3   <= w_funct3_nxt;
      lsuBusy    <= w_busy_nxt;
      reqD       <= w_reqd_nxt;
      wr         <= w_wr_nxt;
      memDAddr   <= w_daddr_nxt;
      memDData   <= w_ddata_nxt;
      done       <= w_done_nxt;
      wbValid    <= w_wbvalid_nxt;
      misaligned <= w_mis_nxt;
      illegal    <= w_ill_nxt;
      loadData   <= w_load_nxt;
      rdOut      <= w_rd_nxt;
    end
  end

endmodule

// File: tb/tb_aqua_lsu_rv32i.sv
// tb_aqua_lsu_rv32i: self-checking bench for aqua_lsu_rv32i with a
// behavioural arbiter/memory and an expected-result model per request.
// Honours AQUA_LSU_RMW_EN when computing sub-word store expectations.
module tb_aqua_lsu_rv32i;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        reqValid = 1'b0, isLoad = 1'b0, isStore = 1'b0;
  logic [2:0]  funct3 = 3'b0;
  logic [31:0] addrIn = '0, storeDataIn = '0;
  logic [4:0]  rdIn = '0;
  logic        lsuBusy, wr, reqD, done, wbValid, misaligned, illegal;
  logic [31:0] memDAddr, memDData, loadData;
  logic [4:0]  rdOut;
  logic        memDReady = 1'b0;
  logic [31:0] memDataOutReg = '0;

  always #5 clk = ~clk;

  aqua_lsu_rv32i #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
    .clk(clk), .reset(reset), .reqValid(reqValid), .isLoad(isLoad),
    .isStore(isStore), .funct3(funct3), .addrIn(addrIn),
    .storeDataIn(storeDataIn), .rdIn(rdIn), .lsuBusy(lsuBusy),
    .memDAddr(memDAddr), .memDData(memDData), .wr(wr), .reqD(reqD),
    .memDReady(memDReady), .memDataOutReg(memDataOutReg), .done(done),
    .wbValid(wbValid), .loadData(loadData), .rdOut(rdOut),
    .misaligned(misaligned), .illegal(illegal)
  );

  int checks = 0, passes = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Arbiter + memory: answers the Nth cycle of a held request
  logic [31:0] mem [64];
  int arb_lat = 1, arb_cnt = 0;
  always @(posedge clk) begin
    #2;
    if (!reqD || memDReady) arb_cnt = 0;
    memDReady = 1'b0;
    memDataOutReg = $urandom;
    if (reqD) begin
      arb_cnt++;
      if (arb_cnt >= arb_lat) begin
        memDReady = 1'b1;
        if (wr) mem[memDAddr[7:2]] = memDData;
        else    memDataOutReg = mem[memDAddr[7:2]];
      end
    end
  end

  // Expected results of the request in flight
  bit          pend = 0;
  int          cyc = 0, e_lat = 0, e_ready_seen = 0;
  bit          e_wbv, e_mis, e_ill, e_bus, e_rmw, e_store;
  logic [31:0] e_ld, e_waddr;
  logic [4:0]  e_rd;
  logic [31:0] m_ld = '0;
  logic [4:0]  m_rd = '0;
  int          last_cyc = 0;
  bit          last_mis = 0, last_ill = 0, last_wbv = 0;
  logic        p_reqd = 0, p_ready = 0, p_wr = 0;
  logic [31:0] p_addr = '0, p_data = '0;

  // Compare process: checks outputs every cycle a request is in flight
  always @(negedge clk) begin
    if (pend) begin
      cyc++;
      chk("busy", 32'(lsuBusy), 32'd1);
      if (reqD) begin
        if (!e_bus) chk("err_path_reqd", 32'(reqD), 32'd0);
        else begin
          chk("daddr", memDAddr, e_waddr);
          chk("wr", 32'(wr), 32'(e_store && (!e_rmw || e_ready_seen > 0)));
        end
        if (p_reqd && !p_ready) begin
          chk("stable_addr", memDAddr, p_addr);
          chk("stable_wr", 32'(wr), 32'(p_wr));
          if (wr) chk("stable_data", memDData, p_data);
        end
      end
      if (p_ready && !(e_rmw && !p_wr)) chk("reqd_drop", 32'(reqD), 32'd0);
      if (memDReady) e_ready_seen++;
      if (done) begin
        chk("latency", 32'(cyc), 32'(e_lat));
        chk("wbValid", 32'(wbValid), 32'(e_wbv));
        chk("misaligned", 32'(misaligned), 32'(e_mis));
        chk("illegal", 32'(illegal), 32'(e_ill));
        chk("loadData", loadData, e_ld);
        chk("rdOut", 32'(rdOut), 32'(e_rd));
        last_cyc = cyc; last_mis = misaligned; last_ill = illegal; last_wbv = wbValid;
        pend = 0;
      end else if (cyc > 40) begin
        chk("done_timeout", 32'(cyc), 32'(e_lat));
        pend = 0;
      end
    end else if (done) begin
      chk("spurious_done", 32'(done), 32'd0);
    end
    p_reqd = reqD; p_ready = memDReady; p_wr = wr; p_addr = memDAddr; p_data = memDData;
  end

  // Issue one request and check it against the model
  task automatic do_op(input bit il, input bit is, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] d,
                       input logic [4:0] rd, input int lat);
    bit valid, mis, ill, err;
    int w, ai, lane;
    logic [31:0] word, v, nw, ob, nb;
    valid = il ? !(f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) : (f3 < 3'd3);
    w  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    ai = int'(a[1:0]);
    mis = valid && ((ai % w) != 0);
    ill = !valid;
`ifndef AQUA_LSU_RMW_EN
    if (!il && w < 4) ill = 1;
`endif
    err = mis || ill;
    word = mem[a[7:2]];
    e_lat = err ? 1 : (il || w == 4) ? lat + 1 : 2 * lat + 1;
    e_bus = !err; e_rmw = !il && w < 4; e_store = !il;
    e_waddr = {a[31:2], 2'b00}; e_ready_seen = 0;
    e_mis = mis; e_ill = ill; e_wbv = il && !err;
    if (il) m_rd = rd;
    e_rd = m_rd;
    if (il && !err) begin
      v = word >> (8 * ai);
      if (w < 4) begin
        v = v & ((32'd1 << (8 * w)) - 32'd1);
        if (!f3[2] && v[8 * w - 1]) v = v - (32'd1 << (8 * w));
      end
      m_ld = v;
    end
    e_ld = m_ld;
    nw = word;
    if (!il && !err) begin
      for (int b = 0; b < w; b++) begin
        lane = ai + b;
        ob = (nw >> (8 * lane)) & 32'hFF;
        nb = (d >> (8 * b)) & 32'hFF;
        nw = nw - (ob << (8 * lane)) + (nb << (8 * lane));
      end
    end
    @(negedge clk);
    reqValid = 1; isLoad = il; isStore = is; funct3 = f3;
    addrIn = a; storeDataIn = d; rdIn = rd; arb_lat = lat;
    @(posedge clk); #1;
    pend = 1; cyc = 0;
    // Keep reqValid high with junk fields while busy; it must be ignored
    for (int k = 0; k < 60 && pend; k++) begin
      @(negedge clk); #1;
      if (pend) begin
        reqValid = 1; isLoad = 1'($urandom); isStore = 1'($urandom);
        funct3 = 3'($urandom); addrIn = $urandom; storeDataIn = $urandom; rdIn = 5'($urandom);
      end else reqValid = 0;
    end
    reqValid = 0; isLoad = 0; isStore = 0;
    if (pend) begin
      chk("driver_timeout", 32'(pend), 32'd0);
      pend = 0;
    end
    if (!il) chk("mem_word", mem[a[7:2]], nw);
  endtask

  initial begin
    logic il, is;
    for (int i = 0; i < 64; i++) mem[i] = $urandom;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(lsuBusy), 0);   chk("rst_reqD", 32'(reqD), 0);
    chk("rst_wr", 32'(wr), 0);          chk("rst_done", 32'(done), 0);
    chk("rst_wbValid", 32'(wbValid), 0); chk("rst_mis", 32'(misaligned), 0);
    chk("rst_ill", 32'(illegal), 0);    chk("rst_loadData", loadData, 0);
    chk("rst_rdOut", 32'(rdOut), 0);    chk("rst_memDAddr", memDAddr, 0);
    chk("rst_memDData", memDData, 0);
    reset = 0;

    // Directed cases with hand-computed results
    mem[0] = 32'hDEADBEEF;
    do_op(1, 0, 3'b010, 32'h100, 32'h0, 5'd7, 2);
    chk("lw_lit_data", loadData, 32'hDEADBEEF);
    chk("lw_lit_rd", 32'(rdOut), 32'd7);
    chk("lw_lit_lat", 32'(last_cyc), 32'd3);
    mem[0] = 32'h80FF1234;
    do_op(1, 0, 3'b000, 32'h103, 32'h0, 5'd3, 1);
    chk("lb_lit", loadData, 32'hFFFFFF80);
    do_op(1, 0, 3'b100, 32'h103, 32'h0, 5'd4, 3);
    chk("lbu_lit", loadData, 32'h00000080);
`ifdef AQUA_LSU_RMW_EN
    mem[0] = 32'h11223344;
    do_op(0, 1, 3'b000, 32'h102, 32'hAA, 5'd0, 2);
    chk("sb_lit_mem", mem[0], 32'h11AA3344);
    chk("sb_lit_lat", 32'(last_cyc), 32'd5);
    chk("sb_lit_wbv", 32'(last_wbv), 32'd0);
`else
    mem[0] = 32'h11223344;
    do_op(0, 1, 3'b001, 32'h100, 32'h5555, 5'd0, 2);
    chk("sh_norm_ill", 32'(last_ill), 32'd1);
    chk("sh_norm_lat", 32'(last_cyc), 32'd1);
    chk("sh_norm_mem", mem[0], 32'h11223344);
`endif
    do_op(1, 0, 3'b001, 32'h101, 32'h0, 5'd9, 2);
    chk("lh_mis_lit", 32'(last_mis), 32'd1);
    chk("lh_mis_lat", 32'(last_cyc), 32'd1);
    do_op(1, 0, 3'b010, 32'h102, 32'h0, 5'd9, 2);
    chk("lw_mis_lit", 32'(last_mis), 32'd1);
    do_op(1, 0, 3'b011, 32'h100, 32'h0, 5'd9, 2);
    chk("ld_ill_lit", 32'(last_ill), 32'd1);
    do_op(1, 1, 3'b010, 32'h104, 32'h0, 5'd11, 1);
    do_op(0, 1, 3'b010, 32'h108, 32'hCAFEF00D, 5'd0, 2);
    chk("sw_lit_mem", mem[2], 32'hCAFEF00D);

    // Request with neither load nor store is not accepted
    @(negedge clk); reqValid = 1; isLoad = 0; isStore = 0;
    @(negedge clk); reqValid = 0;
    chk("no_kind_busy", 32'(lsuBusy), 32'd0);

    // Reset during a load abandons it
    arb_lat = 10;
    @(negedge clk); reqValid = 1; isLoad = 1; isStore = 0; funct3 = 3'b010;
    addrIn = 32'h200; rdIn = 5'd12;
    @(posedge clk); #1; reqValid = 0; isLoad = 0;
    repeat (2) @(negedge clk);
    chk("mid_reqD", 32'(reqD), 32'd1);
    reset = 1;
    @(posedge clk); #1;
    chk("rst_mid_reqD", 32'(reqD), 32'd0);
    chk("rst_mid_busy", 32'(lsuBusy), 32'd0);
    @(negedge clk); reset = 0;
    m_rd = '0; m_ld = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_mid_nodone", 32'(done), 32'd0);
    end
    mem[1] = 32'h0BADC0DE;
    do_op(1, 0, 3'b010, 32'h104, 32'h0, 5'd13, 2);
    chk("post_rst_lw", loadData, 32'h0BADC0DE);

    // Randomized requests
    for (int n = 0; n < 200; n++) begin
      il = 1'($urandom); is = 1'($urandom);
      if (!il && !is) il = 1;
      do_op(il, is, 3'($urandom), $urandom, $urandom, 5'($urandom), $urandom_range(3, 1));
    end

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
